// File: rtl/mpsoc_debug_halt_sequencer.sv
// ---------------------------------------------------------------------------
// mpsoc_debug_halt_sequencer
//
// Cross-trigger halt/resume controller for the per-CPU JTAG debug modules.
// A debugack rising edge on any CPU, or a host halt pulse, makes the block
// request debug mode on every CPU and wait for all acknowledges. A host resume
// pulse releases every CPU together and waits for all acknowledges to drop.
// Each acknowledge phase is bounded by ACK_TIMEOUT cycles. An expired phase
// sets the sticky timeout_err flag.
//
// Parameters
//   NUM_CPU      number of CPUs sequenced (2..16)
//   CPU_IDX_W    width of a CPU index, clog2(NUM_CPU)
//   ACK_TIMEOUT  cycles allowed per acknowledge phase (>= 2)
//   CNT_W        timeout counter width, 2**CNT_W >= ACK_TIMEOUT
//
// Ports
//   clk              in   system clock
//   reset_n          in   asynchronous active-low reset
//   debugack         in   [NUM_CPU] per-CPU "in debug mode" level
//   host_halt_all    in   single-cycle pulse: halt all CPUs
//   host_resume      in   single-cycle pulse: resume all CPUs
//   clr_err          in   single-cycle pulse: clear timeout_err
//   debugreq         out  [NUM_CPU] per-CPU debug request (registered)
//   all_halted       out  HALTED and every debugack high (registered)
//   busy             out  sequencer is in REQ or RESUME (registered)
//   timeout_err      out  sticky: an acknowledge phase timed out
//   first_hit        out  [CPU_IDX_W] lowest CPU whose ack rose at the trigger
//   first_hit_valid  out  first_hit holds a captured index
//
// Configuration macro
//   MPSOC_DEBUG_HIT_CAPTURE_EN  when defined, adds the first_hit and
//                               first_hit_valid outputs and their capture
//                               registers. When undefined, those ports do not
//                               exist.
// ---------------------------------------------------------------------------
module mpsoc_debug_halt_sequencer #(
  parameter int NUM_CPU     = 4,
  parameter int CPU_IDX_W   = 2,
  parameter int ACK_TIMEOUT = 1024,
  parameter int CNT_W       = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_CPU-1:0]   debugack,
  input  logic                 host_halt_all,
  input  logic                 host_resume,
  input  logic                 clr_err,
  output logic [NUM_CPU-1:0]   debugreq,
  output logic                 all_halted,
  output logic                 busy,
  output logic                 timeout_err
`ifdef MPSOC_DEBUG_HIT_CAPTURE_EN
  ,
  output logic [CPU_IDX_W-1:0] first_hit,
  output logic                 first_hit_valid
`endif
);

  // Reject inconsistent parameter sets at elaboration time.
  if ((1 << CPU_IDX_W) < NUM_CPU) begin : g_bad_idx_w
    $error("CPU_IDX_W too narrow for NUM_CPU");
  end
  if ((1 << CNT_W) < ACK_TIMEOUT) begin : g_bad_cnt_w
    $error("CNT_W too narrow for ACK_TIMEOUT");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_HALTED = 2'd2,
    ST_RESUME = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e             r_state;
  state_e             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_next_cnt;
  logic [NUM_CPU-1:0] r_ack_q;
  logic [NUM_CPU-1:0] r_debugreq;
  logic               r_all_halted;
  logic               r_busy;
  logic               r_timeout_err;

  logic [NUM_CPU-1:0] w_rise;
  logic               w_trig;
  logic               w_all_ack;
  logic               w_no_ack;
  logic               w_cnt_last;
  logic               w_timeout;

  // Rising debugack edges are measured against the previous cycle's copy.
  // Because r_ack_q resets to 0, a CPU already in debug mode at reset exit
  // shows up as an edge on the first cycle.
  assign w_rise     = debugack & ~r_ack_q;
  assign w_trig     = host_halt_all | (|w_rise);
  assign w_all_ack  = &debugack;
  assign w_no_ack   = ~|debugack;
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Next-state logic. In IDLE a resume pulse is ignored. In HALTED a halt
  // pulse is ignored, so a simultaneous halt+resume takes the only transition
  // the current state allows.
  // NOTE: every signal driven here gets a default first, so each path assigns
  // it and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_trig) w_next_state = ST_REQ;
      end
      ST_REQ: begin
        if (w_all_ack) begin
          w_next_state = ST_HALTED;
        end else if (w_cnt_last) begin
          w_next_state = ST_HALTED;
          w_timeout    = 1'b1;
        end
      end
      ST_HALTED: begin
        if (host_resume) w_next_state = ST_RESUME;
      end
      ST_RESUME: begin
        if (w_no_ack) begin
          w_next_state = ST_IDLE;
        end else if (w_cnt_last) begin
          w_next_state = ST_IDLE;
          w_timeout    = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // The phase counter clears on every state change. It only advances in the
  // two acknowledge-wait states and saturates at the last timeout cycle.
  always_comb begin
    w_next_cnt = r_cnt;
    if (w_next_state != r_state) begin
      w_next_cnt = '0;
    end else if ((r_state == ST_REQ || r_state == ST_RESUME) && !w_cnt_last) begin
      w_next_cnt = r_cnt + 1'b1;
    end else if (r_state == ST_IDLE || r_state == ST_HALTED) begin
      w_next_cnt = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_ack_q       <= '0;
      r_debugreq    <= '0;
      r_all_halted  <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_ack_q    <= debugack;
      // Outputs are decoded from the next state so that they change on the
      // same edge as the state register.
      r_debugreq <= (w_next_state == ST_REQ || w_next_state == ST_HALTED) ?
                    {NUM_CPU{1'b1}} : {NUM_CPU{1'b0}};
      r_busy     <= (w_next_state == ST_REQ || w_next_state == ST_RESUME);
      // Requires one full cycle in HALTED before all_halted asserts. A resume
      // pulse, or any dropped ack, clears it on the following edge.
      r_all_halted <= (r_state == ST_HALTED) && (w_next_state == ST_HALTED) &&
                      w_all_ack;
      // Setting the error takes priority over clearing it.
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (clr_err) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign debugreq    = r_debugreq;
  assign all_halted  = r_all_halted;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

`ifdef MPSOC_DEBUG_HIT_CAPTURE_EN
  logic [CPU_IDX_W-1:0] r_first_hit;
  logic                 r_first_hit_valid;
  logic [CPU_IDX_W-1:0] w_rise_idx;

  // Priority encoder for the lowest-numbered rising ack. The scan runs from
  // high to low so that the last match, which is the lowest index, wins.
  always_comb begin
    w_rise_idx = '0;
    for (int i = NUM_CPU - 1; i >= 0; i--) begin
      if (w_rise[i]) w_rise_idx = CPU_IDX_W'(i);
    end
  end

  // Capture on every IDLE trigger. A host-only trigger records "no CPU".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_first_hit       <= '0;
      r_first_hit_valid <= 1'b0;
    end else if (r_state == ST_IDLE && w_trig) begin
      r_first_hit       <= (|w_rise) ? w_rise_idx : '0;
      r_first_hit_valid <= |w_rise;
    end
  end

  assign first_hit       = r_first_hit;
  assign first_hit_valid = r_first_hit_valid;
`endif

endmodule

// File: tb/tb_mpsoc_debug_halt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mpsoc_debug_halt_sequencer
//
// Directed testbench for mpsoc_debug_halt_sequencer with default parameters
// (4 CPUs, ACK_TIMEOUT = 1024). Inputs are driven 1 time unit after a rising
// edge. Outputs are checked at the same point, so each check observes the
// registers that the preceding edge updated.
// ---------------------------------------------------------------------------
module tb_mpsoc_debug_halt_sequencer;

  logic       clk;
  logic       reset_n;
  logic [3:0] debugack;
  logic       host_halt_all;
  logic       host_resume;
  logic       clr_err;
  logic [3:0] debugreq;
  logic       all_halted;
  logic       busy;
  logic       timeout_err;
`ifdef MPSOC_DEBUG_HIT_CAPTURE_EN
  logic [1:0] first_hit;
  logic       first_hit_valid;
`endif

  int n_vec = 0;
  int n_err = 0;

  mpsoc_debug_halt_sequencer #(
    .NUM_CPU(4), .CPU_IDX_W(2), .ACK_TIMEOUT(1024), .CNT_W(10)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .debugack      (debugack),
    .host_halt_all (host_halt_all),
    .host_resume   (host_resume),
    .clr_err       (clr_err),
    .debugreq      (debugreq),
    .all_halted    (all_halted),
    .busy          (busy),
    .timeout_err   (timeout_err)
`ifdef MPSOC_DEBUG_HIT_CAPTURE_EN
    ,
    .first_hit       (first_hit),
    .first_hit_valid (first_hit_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; debugack = 4'h0; host_halt_all = 1'b0;
    host_resume = 1'b0; clr_err = 1'b0;
    tick(); tick();
    n_vec++; if (debugreq !== 4'h0) begin n_err++; $display("FAIL rst_debugreq: got %h expected 0", debugreq); end
    n_vec++; if (all_halted !== 1'b0) begin n_err++; $display("FAIL rst_all_halted: got %b expected 0", all_halted); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_timeout_err: got %b expected 0", timeout_err); end
`ifdef MPSOC_DEBUG_HIT_CAPTURE_EN
    n_vec++; if ({first_hit_valid, first_hit} !== 3'b000) begin n_err++; $display("FAIL rst_first_hit: got %b/%0d expected 0/0", first_hit_valid, first_hit); end
`endif
    reset_n = 1'b1;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  // CPU2 enters debug mode. Acks reach all ones 3 cycles later.
  task automatic test_ack_trigger();
    debugack = 4'b0100;
    tick();
    n_vec++; if (debugreq !== 4'hF) begin n_err++; $display("FAIL t1_debugreq: got %h expected f", debugreq); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy: got %b expected 1", busy); end
`ifdef MPSOC_DEBUG_HIT_CAPTURE_EN
    n_vec++; if (first_hit !== 2'd2) begin n_err++; $display("FAIL t1_first_hit: got %0d expected 2", first_hit); end
    n_vec++; if (first_hit_valid !== 1'b1) begin n_err++; $display("FAIL t1_first_hit_valid: got %b expected 1", first_hit_valid); end
`endif
    tick(); tick();
    debugack = 4'hF;
    tick();
    n_vec++; if (all_halted !== 1'b0) begin n_err++; $display("FAIL t1_all_halted_a1: got %b expected 0", all_halted); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t1_busy_a1: got %b expected 0", busy); end
    n_vec++; if (debugreq !== 4'hF) begin n_err++; $display("FAIL t1_debugreq_a1: got %h expected f", debugreq); end
    tick();
    n_vec++; if (all_halted !== 1'b1) begin n_err++; $display("FAIL t1_all_halted_a2: got %b expected 1", all_halted); end
  endtask

  task automatic test_resume();
    host_resume = 1'b1;
    tick();
    host_resume = 1'b0;
    n_vec++; if (debugreq !== 4'h0) begin n_err++; $display("FAIL t2_debugreq: got %h expected 0", debugreq); end
    n_vec++; if (all_halted !== 1'b0) begin n_err++; $display("FAIL t2_all_halted: got %b expected 0", all_halted); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL t2_busy_resume: got %b expected 1", busy); end
    debugack = 4'h0;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t2_busy_idle: got %b expected 0", busy); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL t2_timeout_err: got %b expected 0", timeout_err); end
    n_vec++; if (debugreq !== 4'h0) begin n_err++; $display("FAIL t2_debugreq_idle: got %h expected 0", debugreq); end
  endtask

  // Host halt while CPU3 never acknowledges. REQ lasts exactly 1024 cycles.
  task automatic test_timeout();
    host_halt_all = 1'b1;
    tick();
    host_halt_all = 1'b0;
    debugack = 4'b0111;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL t3_busy_start: got %b expected 1", busy); end
    repeat (1023) tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL t3_busy_last: got %b expected 1", busy); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL t3_err_early: got %b expected 0", timeout_err); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t3_busy_end: got %b expected 0", busy); end
    n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL t3_err_set: got %b expected 1", timeout_err); end
    n_vec++; if (debugreq !== 4'hF) begin n_err++; $display("FAIL t3_debugreq: got %h expected f", debugreq); end
`ifdef MPSOC_DEBUG_HIT_CAPTURE_EN
    n_vec++; if ({first_hit_valid, first_hit} !== 3'b000) begin n_err++; $display("FAIL t3_first_hit: got %b/%0d expected 0/0", first_hit_valid, first_hit); end
`endif
    tick();
    n_vec++; if (all_halted !== 1'b0) begin n_err++; $display("FAIL t3_all_halted: got %b expected 0", all_halted); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL t3_err_clr: got %b expected 0", timeout_err); end
  endtask

  // In HALTED, one CPU drops its ack without a resume pulse.
  task automatic test_ack_drop();
    debugack = 4'hF;
    tick();
    n_vec++; if (all_halted !== 1'b1) begin n_err++; $display("FAIL drop_all_halted_up: got %b expected 1", all_halted); end
    debugack = 4'b1110;
    tick();
    n_vec++; if (all_halted !== 1'b0) begin n_err++; $display("FAIL drop_all_halted_down: got %b expected 0", all_halted); end
    tick();
    n_vec++; if (debugreq !== 4'hF) begin n_err++; $display("FAIL drop_debugreq: got %h expected f", debugreq); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_busy: got %b expected 0", busy); end
    debugack = 4'hF;
    tick();
    n_vec++; if (all_halted !== 1'b1) begin n_err++; $display("FAIL drop_all_halted_back: got %b expected 1", all_halted); end
    host_resume = 1'b1;
    tick();
    host_resume = 1'b0;
    debugack = 4'h0;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_back_idle: got %b expected 0", busy); end
  endtask

  // CPU1 and CPU3 rise together with a host halt pulse.
  task automatic test_simultaneous();
    debugack = 4'b1010;
    host_halt_all = 1'b1;
    tick();
    host_halt_all = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL t4_busy: got %b expected 1", busy); end
    n_vec++; if (debugreq !== 4'hF) begin n_err++; $display("FAIL t4_debugreq: got %h expected f", debugreq); end
`ifdef MPSOC_DEBUG_HIT_CAPTURE_EN
    n_vec++; if (first_hit !== 2'd1) begin n_err++; $display("FAIL t4_first_hit: got %0d expected 1", first_hit); end
    n_vec++; if (first_hit_valid !== 1'b1) begin n_err++; $display("FAIL t4_first_hit_valid: got %b expected 1", first_hit_valid); end
`endif
    tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL t4_busy_hold: got %b expected 1", busy); end
    debugack = 4'hF;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t4_busy_done: got %b expected 0", busy); end
    tick();
    n_vec++; if (all_halted !== 1'b1) begin n_err++; $display("FAIL t4_all_halted: got %b expected 1", all_halted); end
    host_resume = 1'b1;
    tick();
    host_resume = 1'b0;
    debugack = 4'h0;
    tick();
  endtask

  // Assert reset mid-REQ while acks are high, then release.
  task automatic test_reset_mid();
    host_halt_all = 1'b1;
    tick();
    host_halt_all = 1'b0;
    debugack = 4'b0011;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL t5_busy_req: got %b expected 1", busy); end
    #1;
    reset_n = 1'b0;
    #1;
    n_vec++; if (debugreq !== 4'h0) begin n_err++; $display("FAIL t5_async_debugreq: got %h expected 0", debugreq); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t5_async_busy: got %b expected 0", busy); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL t5_async_err: got %b expected 0", timeout_err); end
    tick();
    reset_n = 1'b1;
    tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL t5_retrigger_busy: got %b expected 1", busy); end
    n_vec++; if (debugreq !== 4'hF) begin n_err++; $display("FAIL t5_retrigger_debugreq: got %h expected f", debugreq); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL t5_no_err: got %b expected 0", timeout_err); end
`ifdef MPSOC_DEBUG_HIT_CAPTURE_EN
    n_vec++; if ({first_hit_valid, first_hit} !== 3'b100) begin n_err++; $display("FAIL t5_first_hit: got %b/%0d expected 1/0", first_hit_valid, first_hit); end
`endif
  endtask

  // Halt and resume pulses in the same cycle while HALTED, then a stray resume in IDLE.
  task automatic test_halt_and_resume();
    debugack = 4'hF;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t6_halted_busy: got %b expected 0", busy); end
    host_halt_all = 1'b1;
    host_resume   = 1'b1;
    tick();
    host_halt_all = 1'b0;
    host_resume   = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL t6_resume_busy: got %b expected 1", busy); end
    n_vec++; if (debugreq !== 4'h0) begin n_err++; $display("FAIL t6_resume_debugreq: got %h expected 0", debugreq); end
    debugack = 4'h0;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t6_idle_busy: got %b expected 0", busy); end
    host_resume = 1'b1;
    tick();
    host_resume = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t6_idle_resume_busy: got %b expected 0", busy); end
    n_vec++; if (debugreq !== 4'h0) begin n_err++; $display("FAIL t6_idle_resume_debugreq: got %h expected 0", debugreq); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t6_idle_stays: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_ack_trigger();
    test_resume();
    test_timeout();
    test_ack_drop();
    test_simultaneous();
    test_reset_mid();
    test_halt_and_resume();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
